// File: rtl/laconic_term_scheduler_if.sv
// Stream of signed operand pairs in, packed LANES-wide term-pair beats out.
// master = environment side (drives pairs, consumes beats); slave = scheduler side.
interface laconic_term_scheduler_if #(
    parameter int LANES = 16,
    parameter int EXP_W = 3,
    parameter int OP_W  = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [OP_W-1:0]          s_act;
    logic [OP_W-1:0]          s_wgt;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [LANES-1:0]         m_in_applied;
    logic [LANES*EXP_W-1:0]   m_t0;
    logic [LANES*EXP_W-1:0]   m_t1;
    logic [LANES-1:0]         m_s0;
    logic [LANES-1:0]         m_s1;
    logic                     m_last;

    modport master (
        output s_valid, s_act, s_wgt, s_last, m_ready,
        input  s_ready, m_valid, m_in_applied, m_t0, m_t1, m_s0, m_s1, m_last
    );

    modport slave (
        input  s_valid, s_act, s_wgt, s_last, m_ready,
        output s_ready, m_valid, m_in_applied, m_t0, m_t1, m_s0, m_s1, m_last
    );
endinterface

// File: rtl/laconic_term_scheduler.sv
// Recodes signed act/wgt pairs into NAF term pairs and packs them densely into LANES-wide beats.
// Latency: pair accepted in cycle N appears on m_* in cycle N+1; beat slots are registered.
// Backpressure: s_ready drops when a full beat stalls or while flushing; m_* hold while m_valid & !m_ready.
module laconic_term_scheduler #(
    parameter int LANES = 16,
    parameter int EXP_W = 3,
    parameter int OP_W  = 8
) (
    input  logic clk,
    input  logic rst,
    laconic_term_scheduler_if.slave bus
);
    localparam int SLOTS = 2 * LANES;
    localparam int CW    = $clog2(SLOTS);
    localparam int MAXT  = 4;
    localparam int MAXK  = MAXT * MAXT;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    typedef struct packed {
        logic             applied;
        logic             s0;
        logic             s1;
        logic [EXP_W-1:0] t0;
        logic [EXP_W-1:0] t1;
    } slot_t;

    typedef struct packed {
        logic [2:0]                  n;
        logic [MAXT-1:0][EXP_W-1:0]  e;
        logic [MAXT-1:0]             neg;
    } terms_t;

    typedef enum logic {FILL, FLUSH} state_t;

    // NAF of |x| via (3m ^ m) carry trick; terms listed by descending exponent.
    function automatic terms_t naf_terms(input logic [OP_W-1:0] x);
        logic [OP_W:0] mag, half, trip, c, pos, negd;
        terms_t t;
        t    = '0;
        mag  = x[OP_W-1] ? ({1'b0, ~x} + 1'b1) : {1'b0, x};
        half = mag >> 1;
        trip = mag + half;
        c    = half ^ trip;
        pos  = trip & c;
        negd = half & c;
        for (int i = OP_W; i >= 0; i--) begin
            if ((pos[i] | negd[i]) && t.n < 3'(MAXT)) begin
                t.e[t.n[1:0]]   = EXP_W'(i);
                t.neg[t.n[1:0]] = negd[i] ^ x[OP_W-1];
                t.n             = t.n + 3'd1;
            end
        end
        return t;
    endfunction

    state_t                 state;
    logic [CW-1:0]          count, cnt_pop, count_nxt;
    slot_t [SLOTS-1:0]      slots, popped, slots_nxt;
    slot_t [MAXK-1:0]       pairs;
    logic [4:0]             k;
    terms_t                 ta, tb;
    logic                   full, fire, push;

    assign ta   = naf_terms(bus.s_act);
    assign tb   = naf_terms(bus.s_wgt);
    assign full = (count >= LANES_C);

    assign bus.m_valid = !rst && ((state == FLUSH) || full);
    assign bus.m_last  = (state == FLUSH) && (count <= LANES_C);
    assign bus.s_ready = !rst && (state == FILL) && (!full || bus.m_ready);
    assign fire        = bus.m_valid & bus.m_ready;
    assign push        = bus.s_valid & bus.s_ready;

    always_comb begin
        pairs = '0;
        k     = '0;
        for (int a = 0; a < MAXT; a++) begin
            for (int b = 0; b < MAXT; b++) begin
                if (3'(a) < ta.n && 3'(b) < tb.n) begin
                    pairs[k[3:0]] = '{applied: 1'b1, s0: ta.neg[a], s1: tb.neg[b],
                                      t0: ta.e[a], t1: tb.e[b]};
                    k = k + 5'd1;
                end
            end
        end
    end

    // Shifting by a full LANES is exact even for a short pop: slots past count are always zero.
    always_comb begin
        popped  = slots;
        cnt_pop = count;
        if (fire) begin
            for (int j = 0; j < SLOTS - LANES; j++) popped[j] = slots[j + LANES];
            for (int j = SLOTS - LANES; j < SLOTS; j++) popped[j] = '0;
            cnt_pop = (count > LANES_C) ? (count - LANES_C) : '0;
        end
        slots_nxt = popped;
        count_nxt = cnt_pop;
        if (push) begin
            for (int p = 0; p < MAXK; p++) begin
                if (p < int'(k)) slots_nxt[CW'(int'(cnt_pop) + p)] = pairs[p];
            end
            count_nxt = cnt_pop + CW'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            count <= '0;
            slots <= '0;
        end else begin
            slots <= slots_nxt;
            count <= count_nxt;
            case (state)
                FILL:  if (push && bus.s_last) state <= FLUSH;
                FLUSH: if (fire && bus.m_last) state <= FILL;
            endcase
        end
    end

    always_comb begin
        bus.m_in_applied = '0;
        bus.m_t0         = '0;
        bus.m_t1         = '0;
        bus.m_s0         = '0;
        bus.m_s1         = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.m_in_applied[i]          = slots[i].applied;
            bus.m_s0[i]                  = slots[i].s0;
            bus.m_s1[i]                  = slots[i].s1;
            bus.m_t0[EXP_W*i +: EXP_W]   = slots[i].t0;
            bus.m_t1[EXP_W*i +: EXP_W]   = slots[i].t1;
        end
    end
endmodule

// File: tb/tb_laconic_term_scheduler.sv
// Bench for laconic_term_scheduler: fixed vectors plus randomized products against a pair-list model.
module tb_laconic_term_scheduler;
    localparam int LANES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    laconic_term_scheduler_if #(.LANES(LANES), .EXP_W(3), .OP_W(8)) bus ();
    laconic_term_scheduler #(.LANES(LANES), .EXP_W(3), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef struct packed {
        logic [15:0] app;
        logic [47:0] t0;
        logic [47:0] t1;
        logic [15:0] s0;
        logic [15:0] s1;
        logic        last;
    } beat_t;

    typedef struct { int t0; int t1; bit s0; bit s1; } pair_t;

    int    tests = 0;
    int    fails = 0;
    bit    ready_mode = 1'b0;
    bit    ready_force = 1'b0;
    int    ready_pct = 100;
    beat_t got_q[$];
    beat_t exp_q[$];
    pair_t pend[$];
    int    exp_dot[$];
    int    dot_acc = 0;

    function automatic beat_t cur_beat();
        beat_t b;
        b.app  = bus.m_in_applied;
        b.t0   = bus.m_t0;
        b.t1   = bus.m_t1;
        b.s0   = bus.m_s0;
        b.s1   = bus.m_s1;
        b.last = bus.m_last;
        return b;
    endfunction

    // Consumer readiness changes at posedge+2, after test processes have settled at posedge+1.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.m_ready = ready_mode ? ($urandom_range(99) < ready_pct) : ready_force;
        end
    end

    always @(negedge clk)
        if (!rst && bus.m_valid && bus.m_ready) got_q.push_back(cur_beat());

    // ---------------- reference model ----------------
    function automatic void naf_ref(input int v, output int n, output int e[4], output bit ng[4]);
        int m, pos, cnt, d;
        int ae[8];
        bit an[8];
        m = (v < 0) ? -v : v;
        pos = 0;
        cnt = 0;
        while (m != 0) begin
            if (m % 2 != 0) begin
                d = 2 - (m % 4);
                ae[cnt] = pos;
                an[cnt] = (d < 0);
                cnt++;
                m -= d;
            end
            m /= 2;
            pos++;
        end
        n = cnt;
        for (int i = 0; i < 4; i++) begin e[i] = 0; ng[i] = 1'b0; end
        for (int i = 0; i < cnt; i++) begin
            e[i]  = ae[cnt-1-i];
            ng[i] = an[cnt-1-i] ^ (v < 0);
        end
    endfunction

    function automatic void emit(input int n, input bit last);
        beat_t b;
        pair_t p;
        b = '0;
        for (int i = 0; i < n; i++) begin
            p = pend.pop_front();
            b.app[i]        = 1'b1;
            b.t0[3*i +: 3]  = 3'(p.t0);
            b.t1[3*i +: 3]  = 3'(p.t1);
            b.s0[i]         = p.s0;
            b.s1[i]         = p.s1;
        end
        b.last = last;
        exp_q.push_back(b);
    endfunction

    function automatic void model_push(input int a, input int w, input bit last);
        int na, nw;
        int ea[4], ew[4];
        bit sa[4], sw[4];
        naf_ref(a, na, ea, sa);
        naf_ref(w, nw, ew, sw);
        for (int i = 0; i < na; i++)
            for (int j = 0; j < nw; j++)
                pend.push_back('{ea[i], ew[j], sa[i], sw[j]});
        dot_acc += a * w;
        if (last) begin
            while (pend.size() > LANES) emit(LANES, 1'b0);
            emit(pend.size(), 1'b1);
            exp_dot.push_back(dot_acc);
            dot_acc = 0;
        end else if (pend.size() >= LANES) begin
            emit(LANES, 1'b0);
        end
    endfunction

    function automatic int pe_dot(input beat_t b);
        int s, v;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            if (b.app[i]) begin
                v = 1 << (int'(b.t0[3*i +: 3]) + int'(b.t1[3*i +: 3]));
                s += (b.s0[i] ^ b.s1[i]) ? -v : v;
            end
        end
        return s;
    endfunction

    task automatic clear_model();
        got_q.delete();
        exp_q.delete();
        exp_dot.delete();
        pend.delete();
        dot_acc = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_pair(input int a, input int w, input bit last);
        bit acc;
        acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_act   = 8'(a);
        bus.s_wgt   = 8'(w);
        bus.s_last  = last;
        for (int g = 0; g < 3000 && !acc; g++) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL send_accept act=%0d wgt=%0d: accepted=%0d required=1", a, w, acc);
        end else begin
            model_push(a, w, last);
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 5000; g++) begin
            if (got_q.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); end
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL post_rst_s_ready: got %b required 1", bus.s_ready); end
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL post_rst_m_valid: got %b required 0", bus.m_valid); end
        tests++; if (bus.m_last !== 1'b0) begin fails++; $display("FAIL post_rst_m_last: got %b required 0", bus.m_last); end
        tests++; if (cur_beat() !== beat_t'(0)) begin fails++; $display("FAIL post_rst_beat: got %h required 0", cur_beat()); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        bit ok;
        clear_model();
        ready_mode = 1'b0; ready_force = 1'b0;
        send_pair(30, 7, 1'b1);
        @(negedge clk);
        tests++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL latency_valid: got %b required 1", bus.m_valid); end
        tests++; if (bus.m_last !== 1'b1) begin fails++; $display("FAIL latency_last: got %b required 1", bus.m_last); end
        tests++; if (bus.m_in_applied !== 16'h000F) begin fails++; $display("FAIL latency_app: got %h required 000f", bus.m_in_applied); end
        @(posedge clk); #1;
        ready_force = 1'b1;
        wait_beats(1, ok);
        idle(2);
    endtask

    task automatic test_spec_vectors();
        beat_t e1, e2, e3;
        bit ok;
        e1 = '0; e1.app = 16'h000F; e1.t0 = 48'h26D; e1.t1 = 48'h0C3; e1.s0 = 16'hC; e1.s1 = 16'hA; e1.last = 1'b1;
        e2 = '0; e2.app = 16'h0001; e2.t0 = 48'h7; e2.t1 = 48'h7; e2.s0 = 16'h1; e2.s1 = 16'h1; e2.last = 1'b1;
        e3 = '0; e3.last = 1'b1;
        clear_model();
        ready_mode = 1'b0; ready_force = 1'b1;
        send_pair(30, 7, 1'b1);
        send_pair(-128, -128, 1'b1);
        send_pair(0, 55, 1'b1);
        wait_beats(3, ok);
        idle(3);
        tests++;
        if (!ok || got_q.size() != 3) begin
            fails++; $display("FAIL spec_beat_count: got %0d required 3", got_q.size());
        end else begin
            tests++; if (got_q[0] !== e1) begin fails++; $display("FAIL spec_30x7: got %h required %h", got_q[0], e1); end
            tests++; if (got_q[1] !== e2) begin fails++; $display("FAIL spec_m128sq: got %h required %h", got_q[1], e2); end
            tests++; if (got_q[2] !== e3) begin fails++; $display("FAIL spec_zero: got %h required %h", got_q[2], e3); end
            tests++; if (pe_dot(got_q[0]) != 210) begin fails++; $display("FAIL spec_pe_210: got %0d required 210", pe_dot(got_q[0])); end
            tests++; if (pe_dot(got_q[1]) != 16384) begin fails++; $display("FAIL spec_pe_16384: got %0d required 16384", pe_dot(got_q[1])); end
        end
    endtask

    task automatic test_multi_beat();
        bit ok;
        int s;
        clear_model();
        ready_mode = 1'b0; ready_force = 1'b1;
        send_pair(85, 7, 1'b0);
        send_pair(85, 7, 1'b0);
        send_pair(85, 7, 1'b1);
        wait_beats(2, ok);
        idle(3);
        tests++;
        if (!ok || got_q.size() != 2) begin
            fails++; $display("FAIL multi_count: got %0d required 2", got_q.size());
        end else begin
            tests++; if (got_q[0].app !== 16'hFFFF || got_q[0].last !== 1'b0) begin fails++; $display("FAIL multi_beat0: got app=%h last=%b required app=ffff last=0", got_q[0].app, got_q[0].last); end
            tests++; if (got_q[1].app !== 16'h00FF || got_q[1].last !== 1'b1) begin fails++; $display("FAIL multi_beat1: got app=%h last=%b required app=00ff last=1", got_q[1].app, got_q[1].last); end
            s = pe_dot(got_q[0]) + pe_dot(got_q[1]);
            tests++; if (s != 1785) begin fails++; $display("FAIL multi_pe_sum: got %0d required 1785", s); end
            for (int i = 0; i < 2; i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL multi_model%0d: got %h required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t snap;
        bit ok;
        clear_model();
        ready_mode = 1'b0; ready_force = 1'b0;
        @(negedge clk);
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_low_count: got %b required 1", bus.s_ready); end
        @(posedge clk); #1;
        send_pair(85, 85, 1'b0);
        bus.s_valid = 1'b1; bus.s_act = 8'd3; bus.s_wgt = 8'd3; bus.s_last = 1'b1;
        @(negedge clk);
        snap = cur_beat();
        tests++; if (snap !== exp_q[0]) begin fails++; $display("FAIL bp_full_beat: got %h required %h", snap, exp_q[0]); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready%0d: got %b required 0", c, bus.s_ready); end
            tests++; if (bus.m_valid !== 1'b1 || cur_beat() !== snap) begin fails++; $display("FAIL bp_hold%0d: got v=%b %h required v=1 %h", c, bus.m_valid, cur_beat(), snap); end
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        ready_mode = 1'b1; ready_pct = 50;
        send_pair(3, 3, 1'b1);
        wait_beats(exp_q.size(), ok);
        idle(4);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_model%0d: got %h required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        clear_model();
        ready_mode = 1'b0; ready_force = 1'b0;
        send_pair(85, 7, 1'b0);
        send_pair(30, 7, 1'b1);
        @(negedge clk);
        tests++; if (bus.m_valid !== 1'b1 || bus.m_last !== 1'b1) begin fails++; $display("FAIL rf_in_flush: got v=%b l=%b required v=1 l=1", bus.m_valid, bus.m_last); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rf_m_valid: got %b required 0", bus.m_valid); end
        tests++; if (cur_beat() !== beat_t'(0)) begin fails++; $display("FAIL rf_cleared: got %h required 0", cur_beat()); end
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rf_s_ready: got %b required 1", bus.s_ready); end
        @(posedge clk); #1;
        clear_model();
        ready_mode = 1'b1; ready_pct = 60;
        send_pair(-77, 102, 1'b0);
        send_pair(30, -7, 1'b1);
        wait_beats(exp_q.size(), ok);
        idle(4);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rf_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rf_model%0d: got %h required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    function automatic int pick_operand();
        int sel;
        sel = int'($urandom_range(9));
        if (sel == 0) return -128;
        if (sel == 1) return 0;
        if (sel == 2) return 127;
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic test_random();
        bit ok;
        int np, acc, prod;
        clear_model();
        ready_mode = 1'b1; ready_pct = 65;
        for (int p = 0; p < 40; p++) begin
            np = int'($urandom_range(1, 5));
            for (int q = 0; q < np; q++) begin
                send_pair(pick_operand(), pick_operand(), q == np - 1);
                idle(int'($urandom_range(2)));
            end
        end
        wait_beats(exp_q.size(), ok);
        idle(6);
        tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            acc = 0;
            prod = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
                acc += pe_dot(got_q[i]);
                if (got_q[i].last) begin
                    tests++;
                    if (prod >= exp_dot.size() || acc != exp_dot[prod]) begin
                        fails++; $display("FAIL rand_dot%0d: got %0d required %0d", prod, acc, (prod < exp_dot.size()) ? exp_dot[prod] : 0);
                    end
                    acc = 0;
                    prod++;
                end
            end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_act   = '0;
        bus.s_wgt   = '0;
        bus.s_last  = 1'b0;
        test_reset();
        test_latency();
        test_spec_vectors();
        test_multi_beat();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
